// File: rtl/spi_master.sv
// SPI master: one K_DWIDTH-bit full-duplex transfer per request, MSB first,
// all four CPOL/CPHA modes, SPI half-period of K_CLKDIV system clocks.
module spi_master #(
  parameter int K_DWIDTH = 16,
  parameter int K_CLKDIV = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [K_DWIDTH-1:0] i_data_to_send,
  input  logic                i_valid_data,
  output logic                o_ready,
  output logic [K_DWIDTH-1:0] o_data_received,
  output logic                o_rx_event,
  output logic                o_busy,
  input  logic                i_cpol,
  input  logic                i_cpha,
  output logic                o_spi_clk,
  output logic                o_mosi,
  input  logic                i_miso,
  output logic                o_cs_n
);

  localparam int CW = $clog2(K_CLKDIV);
  localparam int TW = $clog2(2 * K_DWIDTH + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(K_CLKDIV - 1);
  localparam logic [TW-1:0] TOG_LAST   = TW'(2 * K_DWIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tog_q, tog_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  cs_n_q, cs_n_d, spi_clk_q, spi_clk_d, mosi_q, mosi_d;
  logic                  ready_q, ready_d, busy_q, busy_d, rx_event_q, rx_event_d;
  logic [K_DWIDTH-1:0]   data_rx_q, data_rx_d, tx_q, tx_d, rx_q, rx_d;
  logic                  accept, phase_end, toggle, lead, trail, sample, advance;

  assign accept    = (state_q == IDLE) && ready_q && i_valid_data;
  assign phase_end = (state_q != IDLE) && (cnt_q == '0);
  // SHIFT keeps running one more half-period after the last toggle before HOLD
  assign toggle    = phase_end && ((state_q == SETUP) ||
                                   ((state_q == SHIFT) && (tog_q != TOG_LAST)));
  assign lead      = toggle && !tog_q[0];
  assign trail     = toggle &&  tog_q[0];
  assign sample    = cpha_q ? trail : lead;
  assign advance   = cpha_q ? lead  : trail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (phase_end) state_d = SHIFT;
      SHIFT:   if (phase_end && (tog_q == TOG_LAST)) state_d = HOLD;
      HOLD:    if (phase_end) state_d = GAP;
      GAP:     if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_d != state_q) || toggle) begin
      if (state_d != IDLE) cnt_d = CNT_RELOAD;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - 1'b1;
    end

    tog_d  = accept ? '0 : (toggle ? tog_q + 1'b1 : tog_q);
    cpol_d = accept ? i_cpol : cpol_q;
    cpha_d = accept ? i_cpha : cpha_q;

    // CPHA=1 keeps the MSB in tx so the first leading edge re-presents it
    tx_d = tx_q;
    if (accept)       tx_d = i_cpha ? i_data_to_send : (i_data_to_send << 1);
    else if (advance) tx_d = tx_q << 1;
    rx_d = sample ? {rx_q[K_DWIDTH-2:0], i_miso} : rx_q;

    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    mosi_d = cs_n_d ? 1'b0 : mosi_q;
    if (accept)       mosi_d = i_data_to_send[K_DWIDTH-1];
    else if (advance) mosi_d = tx_q[K_DWIDTH-1];

    spi_clk_d = (state_q == IDLE) ? i_cpol : (spi_clk_q ^ toggle);

    ready_d    = (state_d == IDLE);
    busy_d     = !ready_d;
    rx_event_d = (state_q == HOLD) && phase_end;
    data_rx_d  = rx_event_d ? rx_q : data_rx_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      tog_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      spi_clk_q  <= 1'b0;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      rx_event_q <= 1'b0;
      data_rx_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tog_q      <= tog_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      cs_n_q     <= cs_n_d;
      spi_clk_q  <= spi_clk_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rx_event_q <= rx_event_d;
      data_rx_q  <= data_rx_d;
    end
  end

  // Shift registers are fully rewritten every transfer, so they carry no reset
  always_ff @(posedge i_clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign o_ready         = ready_q;
  assign o_busy          = busy_q;
  assign o_rx_event      = rx_event_q;
  assign o_data_received = data_rx_q;
  assign o_cs_n          = cs_n_q;
  assign o_spi_clk       = spi_clk_q;
  assign o_mosi          = mosi_q;

endmodule
